debounce_array: RTL and testbench
=================================

DEBOUNCE_ARRAY -- requirements
Module: debounce_array

Interface
REQ-001 Parameter N_CH, default 4: number of independent push-button channels; legal range 1..32.
REQ-002 Parameter CNT_VAL, default 500_000: consecutive steady synchronised samples needed to accept a new level; legal minimum 2.
REQ-003 Parameter LONG_VAL, default 50_000_000: clocks a channel stays pressed before a long press is reported; legal minimum 1.
REQ-004 Parameter INV_MASK, N_CH bits, default all zeros: a set bit marks an active-low button, inverted before synchronisation.
REQ-005 clk  input  1  single system clock; every flop is clocked on its rising edge.
REQ-006 arst_n  input  1  asynchronous, active-low reset.
REQ-007 push_btn  input  N_CH  raw asynchronous button levels, bit i = channel i.
REQ-008 pb_stbl  output  N_CH  debounced level, 1 = pressed.
REQ-009 pb_rise  output  N_CH  one-clock pulse on each accepted press.
REQ-010 pb_fall  output  N_CH  one-clock pulse on each accepted release.
REQ-011 pb_long  output  N_CH  one-clock pulse when a press reaches LONG_VAL clocks.
REQ-012 pb_held  output  N_CH  level; high from the pb_long pulse until release.

Function
REQ-013 Channels shall be fully independent; no channel's state shall affect another's.
REQ-014 Each channel shall XOR its raw input with its INV_MASK bit, then pass it through a two-flop synchroniser (s1, s2).
REQ-015 Debounce counter: if s2 equals pb_stbl, cnt is cleared to 0; otherwise cnt increments by 1.
REQ-016 When s2 differs from pb_stbl and cnt equals CNT_VAL-1, that edge shall load pb_stbl from s2 and clear cnt.
REQ-017 Any return of s2 to the pb_stbl value before acceptance shall clear cnt, so bounces restart the qualification.
REQ-018 A steady input change shall appear on pb_stbl exactly CNT_VAL+2 rising edges after the first edge that samples it.
REQ-019 pb_rise and pb_fall shall be registered and high for exactly the one cycle after pb_stbl changes 0->1 or 1->0 respectively.
REQ-020 Hold counter: clears while pb_stbl=0, increments while pb_stbl=1, and saturates at LONG_VAL without wrapping.
REQ-021 pb_long shall pulse for one cycle on the edge where the hold counter goes from LONG_VAL-1 to LONG_VAL; pb_held shall set on that same edge.
REQ-022 pb_held shall clear on the edge where pb_stbl goes to 0, coinciding with the pb_fall pulse.
REQ-023 A release before LONG_VAL shall produce no pb_long; exactly one pb_long is issued per press, however long it is held.
REQ-024 Counter widths shall be $clog2(CNT_VAL+1) and $clog2(LONG_VAL+1); no counter shall ever wrap.
REQ-025 pb_rise and pb_fall shall never be high in the same cycle on one channel; pb_long may coincide with neither.

Reset
REQ-026 While arst_n=0, s1, s2, pb_stbl, pb_rise, pb_fall, pb_long, pb_held and all counters shall be 0, independent of clk.
REQ-027 Reset asserted mid-qualification or mid-hold shall discard progress; after release, outputs stay 0 until a fresh full qualification completes.
REQ-028 An input held pressed through reset release shall yield pb_rise CNT_VAL+2 edges after the first post-reset edge.

Structure
REQ-029 Shared package debounce_pkg shall hold the count-width function and the default CNT_VAL and LONG_VAL constants.
REQ-030 Per-channel logic shall live in one sub-module, debounce_ch, instantiated N_CH times by a generate loop; the top level contains no other logic.

Verification
REQ-031 CNT_VAL=4, N_CH=2: push_btn[0] goes 0->1 and holds -> pb_stbl[0]=1 at edge 6, pb_rise[0] for one cycle, channel 1 outputs stay 0.
REQ-032 CNT_VAL=4: ch0 toggles 1,0,1 every 2 clocks, then holds 1 -> no rise during bouncing; pb_rise 6 edges after the last toggle.
REQ-033 CNT_VAL=4, LONG_VAL=10: hold ch0 for 30 clocks -> exactly one pb_long 10 edges after pb_rise, pb_held high until pb_fall.
REQ-034 INV_MASK=2'b10: push_btn[1] held 1 -> pb_stbl[1]=0; drive 0 -> pb_stbl[1]=1 after 6 edges.
REQ-035 Assert arst_n=0 at cnt=2 and also while pb_held=1 -> all outputs 0 immediately (asynchronously); after release, behaviour matches REQ-028.
REQ-036 Both channels change on the same edge -> identical, simultaneous pb_rise on both channels.

Source files
------------

// File: rtl/debounce_pkg.sv
// debounce_pkg: shared defaults and counter-width helper for the debounce array
package debounce_pkg;
  localparam int unsigned CNT_VAL_DEF = 500_000;
  localparam int unsigned LONG_VAL_DEF = 50_000_000;
  function automatic int unsigned cnt_w(input int unsigned v);
    return (v < 1) ? 1 : $clog2(v + 1);
  endfunction
endpackage

// File: rtl/debounce_ch.sv
// debounce_ch: one push-button channel with synchroniser, debounce, edge and long-press detection
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int unsigned CNT_VAL = CNT_VAL_DEF,
  parameter int unsigned LONG_VAL = LONG_VAL_DEF,
  parameter logic INV = 1'b0
) (
  input  logic clk,
  input  logic arst_n,
  input  logic btn_i,
  output logic stbl_o,
  output logic rise_o,
  output logic fall_o,
  output logic long_o,
  output logic held_o
);
  localparam int unsigned CW = cnt_w(CNT_VAL);
  localparam int unsigned LW = cnt_w(LONG_VAL);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_VAL - 1);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_VAL - 1);
  localparam logic [LW-1:0] LONG_MAX = LW'(LONG_VAL);
  logic s1_q, s2_q, stbl_q, stbl_d, rise_q, fall_q, long_q, long_d, held_q, held_d, accept;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] hold_q, hold_d;
  // a long press that is released on the very edge it matures is dropped, so pb_long never meets pb_fall
  always_comb begin
    accept = (s2_q != stbl_q) && (cnt_q == CNT_LAST);
    stbl_d = accept ? s2_q : stbl_q;
    cnt_d = (s2_q == stbl_q || accept) ? '0 : cnt_q + 1'b1;
    hold_d = !stbl_q ? '0 : (hold_q == LONG_MAX ? hold_q : hold_q + 1'b1);
    long_d = stbl_q && stbl_d && (hold_q == LONG_LAST);
    held_d = stbl_d && (held_q || long_d);
  end
  // all channel state, cleared asynchronously by reset
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      {s1_q, s2_q, stbl_q, rise_q, fall_q, long_q, held_q} <= '0;
      cnt_q <= '0;
      hold_q <= '0;
    end else begin
      s1_q <= btn_i ^ INV;
      s2_q <= s1_q;
      stbl_q <= stbl_d;
      cnt_q <= cnt_d;
      hold_q <= hold_d;
      rise_q <= stbl_d && !stbl_q;
      fall_q <= !stbl_d && stbl_q;
      long_q <= long_d;
      held_q <= held_d;
    end
  end
  assign stbl_o = stbl_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
  assign long_o = long_q;
  assign held_o = held_q;
endmodule

// File: rtl/debounce_array.sv
// debounce_array: N_CH independent debounced push-button channels
module debounce_array
  import debounce_pkg::*;
#(
  parameter int unsigned N_CH = 4,
  parameter int unsigned CNT_VAL = CNT_VAL_DEF,
  parameter int unsigned LONG_VAL = LONG_VAL_DEF,
  parameter logic [N_CH-1:0] INV_MASK = '0
) (
  input  logic            clk,
  input  logic            arst_n,
  input  logic [N_CH-1:0] push_btn,
  output logic [N_CH-1:0] pb_stbl,
  output logic [N_CH-1:0] pb_rise,
  output logic [N_CH-1:0] pb_fall,
  output logic [N_CH-1:0] pb_long,
  output logic [N_CH-1:0] pb_held
);
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_ch #(
      .CNT_VAL(CNT_VAL),
      .LONG_VAL(LONG_VAL),
      .INV(INV_MASK[i])
    ) u_ch (
      .clk(clk),
      .arst_n(arst_n),
      .btn_i(push_btn[i]),
      .stbl_o(pb_stbl[i]),
      .rise_o(pb_rise[i]),
      .fall_o(pb_fall[i]),
      .long_o(pb_long[i]),
      .held_o(pb_held[i])
    );
  end
endmodule

// File: tb/tb_debounce_array.sv
// tb_debounce_array: directed and randomized checks of debounce_array against a run-length model
module tb_debounce_array;
  localparam int N_CH = 2;
  localparam int CNT_VAL = 4;
  localparam int LONG_VAL = 10;
  localparam logic [N_CH-1:0] INV_MASK = 2'b10;
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic [N_CH-1:0] push_btn = 2'b10;
  logic [N_CH-1:0] pb_stbl, pb_rise, pb_fall, pb_long, pb_held;
  int checks = 0;
  int failures = 0;
  debounce_array #(
    .N_CH(N_CH),
    .CNT_VAL(CNT_VAL),
    .LONG_VAL(LONG_VAL),
    .INV_MASK(INV_MASK)
  ) dut (
    .clk(clk),
    .arst_n(arst_n),
    .push_btn(push_btn),
    .pb_stbl(pb_stbl),
    .pb_rise(pb_rise),
    .pb_fall(pb_fall),
    .pb_long(pb_long),
    .pb_held(pb_held)
  );
  always #5 clk = ~clk;
  // model: synchroniser pipe, run length of disagreeing samples, age of an accepted press
  logic [N_CH-1:0] m_s1 = '0, m_s2 = '0, m_stbl = '0, m_rise = '0, m_fall = '0, m_long = '0, m_held = '0;
  int run [N_CH];
  int age [N_CH];
  always @(posedge clk or negedge arst_n) begin
    bit prev, nxt;
    if (!arst_n) begin
      {m_s1, m_s2, m_stbl, m_rise, m_fall, m_long, m_held} = '0;
      for (int c = 0; c < N_CH; c++) begin
        run[c] = 0;
        age[c] = 0;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        prev = m_stbl[c];
        nxt = prev;
        if (m_s2[c] != prev) begin
          run[c]++;
          if (run[c] == CNT_VAL) begin
            nxt = m_s2[c];
            run[c] = 0;
          end
        end else run[c] = 0;
        m_rise[c] = !prev && nxt;
        m_fall[c] = prev && !nxt;
        age[c] = prev ? age[c] + 1 : 0;
        m_long[c] = prev && nxt && (age[c] == LONG_VAL);
        m_held[c] = nxt && (m_held[c] || m_long[c]);
        m_s2[c] = m_s1[c];
        m_s1[c] = push_btn[c] ^ INV_MASK[c];
        m_stbl[c] = nxt;
      end
    end
  end
  wire [5*N_CH-1:0] outs = {pb_stbl, pb_rise, pb_fall, pb_long, pb_held};
  wire [5*N_CH-1:0] m_outs = {m_stbl, m_rise, m_fall, m_long, m_held};
  // every cycle, away from the active edge
  always @(negedge clk) begin
    checks++;
    if (outs !== m_outs) begin
      failures++;
      $display("FAIL cycle_compare t=%0t dut=%b model=%b", $time, outs, m_outs);
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", nm, $time, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  int left [N_CH];
  initial begin
    #12;
    chk("reset_outs", 32'(outs), 0);
    #1 arst_n = 1'b1;
    tick(1);
    push_btn[0] = 1'b1;
    tick(5);
    chk("pre_accept_stbl0", 32'(pb_stbl[0]), 0);
    tick(1);
    chk("accept_edge6_stbl", 32'(pb_stbl), 32'h1);
    chk("rise_edge6", 32'(pb_rise), 32'h1);
    tick(1);
    chk("rise_one_cycle", 32'(pb_rise), 0);
    tick(8);
    chk("no_long_early", 32'(pb_long), 0);
    tick(1);
    chk("long_edge10", 32'(pb_long), 32'h1);
    chk("held_set", 32'(pb_held), 32'h1);
    tick(1);
    chk("long_one_cycle", 32'(pb_long), 0);
    tick(19);
    chk("held_stays", 32'(pb_held), 32'h1);
    push_btn[0] = 1'b0;
    tick(5);
    chk("held_before_fall", 32'(pb_held), 32'h1);
    tick(1);
    chk("fall_edge6", 32'(pb_fall), 32'h1);
    chk("held_clear_at_fall", 32'(pb_held), 0);
    chk("ch1_idle", 32'(pb_stbl[1]), 0);
    tick(4);
    push_btn[0] = 1'b1;
    tick(2);
    push_btn[0] = 1'b0;
    tick(2);
    push_btn[0] = 1'b1;
    tick(5);
    chk("bounce_no_accept", 32'(pb_stbl[0]), 0);
    tick(1);
    chk("bounce_rise", 32'(pb_rise), 32'h1);
    push_btn[0] = 1'b0;
    tick(8);
    chk("inv_idle_low", 32'(pb_stbl[1]), 0);
    push_btn[1] = 1'b0;
    tick(5);
    chk("inv_pre_accept", 32'(pb_stbl[1]), 0);
    tick(1);
    chk("inv_accept", 32'(pb_stbl), 32'h2);
    chk("inv_rise", 32'(pb_rise), 32'h2);
    push_btn[1] = 1'b1;
    tick(8);
    push_btn = 2'b01;
    tick(6);
    chk("simul_rise", 32'(pb_rise), 32'h3);
    push_btn = 2'b10;
    tick(8);
    push_btn[0] = 1'b1;
    tick(4);
    #2 arst_n = 1'b0;
    #1 chk("reset_midqual", 32'(outs), 0);
    tick(2);
    #2 arst_n = 1'b1;
    tick(5);
    chk("post_reset_no_early", 32'(pb_stbl), 0);
    tick(1);
    chk("post_reset_rise", 32'(pb_rise), 32'h1);
    tick(10);
    chk("held_before_reset", 32'(pb_held), 32'h1);
    #2 arst_n = 1'b0;
    #1 chk("reset_midhold", 32'(outs), 0);
    tick(1);
    #2 arst_n = 1'b1;
    tick(5);
    chk("post_reset2_no_early", 32'(pb_stbl), 0);
    tick(1);
    chk("post_reset2_rise", 32'(pb_rise), 32'h1);
    push_btn = 2'b10;
    tick(10);
    for (int c = 0; c < N_CH; c++) left[c] = 1;
    for (int k = 0; k < 4000; k++) begin
      for (int c = 0; c < N_CH; c++) begin
        left[c]--;
        if (left[c] <= 0) begin
          push_btn[c] = ~push_btn[c];
          left[c] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 30));
        end
      end
      if (k % 1000 == 999) begin
        #2 arst_n = 1'b0;
        #1 chk("rand_reset", 32'(outs), 0);
        tick(1);
        #2 arst_n = 1'b1;
      end
      tick(1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
